// File: rtl/fft_out_reorder.sv
// fft_out_reorder
//   Output-side frame buffer for the fft block. Each incoming frame of
//   N_POINT samples is stored in one half of a ping-pong memory. The
//   frame is then replayed in natural bin order over a valid/ready
//   handshake. A frame that arrives while both banks are still occupied
//   is dropped as a whole, and overflow pulses when that happens.
//
//   Build option: define FFT_BITREV_EN when the upstream fft emits bins in
//   bit-reversed order. Samples are then written to the bit-reversed
//   address, so the readout is in natural order. Without the macro the
//   block is a plain frame buffer that preserves arrival order.
//
// Ports
//   clk           in  clock
//   rst_n         in  asynchronous active-low reset
//   data_in       in  FFT sample (fft.data_out)
//   data_in_valid in  sample strobe (fft.data_out_valid), no backpressure
//   dout          out reordered sample, held while dout_ready is low
//   dout_valid    out dout holds a valid bin
//   dout_ready    in  downstream accepts the current bin
//   dout_index    out bin number of dout
//   dout_last     out high together with bin N_POINT-1
//   overflow      out one-cycle pulse when an incoming frame is dropped

module fft_out_reorder #(
    parameter int N_POINT    = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          data_in_valid,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(N_POINT)-1:0]    dout_index,
    output logic                          dout_last,
    output logic                          overflow
);

    localparam int N_NUM_BIT = $clog2(N_POINT);
    localparam logic [N_NUM_BIT-1:0] CNT_LAST = N_NUM_BIT'(N_POINT - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    // Ping-pong storage: the top address bit selects the bank.
    logic [DATA_WIDTH-1:0] mem_q [0:2*N_POINT-1];

    logic [1:0]            bank_full_q, bank_full_d;
    logic                  wr_bank_q,   wr_bank_d;
    logic                  rd_bank_q,   rd_bank_d;
    logic [N_NUM_BIT-1:0]  wr_cnt_q,    wr_cnt_d;
    logic [N_NUM_BIT-1:0]  rd_cnt_q,    rd_cnt_d;
    logic                  dropping_q,  dropping_d;
    logic [0:0]            state_q,     state_d;
    logic [DATA_WIDTH-1:0] dout_q,      dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  overflow_q,  overflow_d;

    logic                  wr_en;
    logic [N_NUM_BIT:0]    wr_addr;
    logic [N_NUM_BIT-1:0]  wr_offset;
    logic                  rd_advance;
    logic [N_NUM_BIT-1:0]  rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_clear;
    logic                  first_sample;
    logic                  clear_wr_bank;
    logic                  drop_first;
    logic                  drop_cur;

`ifdef FFT_BITREV_EN
    function automatic logic [N_NUM_BIT-1:0] bit_rev(input logic [N_NUM_BIT-1:0] v);
        logic [N_NUM_BIT-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N_NUM_BIT; i++) begin
            r[i] = v[N_NUM_BIT-1-i];
        end
        return r;
    endfunction

    assign wr_offset = bit_rev(wr_cnt_q);
`else
    assign wr_offset = wr_cnt_q;
`endif

    assign wr_addr = {wr_bank_q, wr_offset};

    // The registered dout must already show the next bin when the current
    // one is accepted. The read address therefore looks one ahead on an
    // accepted non-final beat.
    assign rd_advance = (state_q == ST_STREAM) && dout_valid_q && dout_ready
                        && (rd_cnt_q != CNT_LAST);
    assign rd_addr    = rd_advance ? rd_cnt_q + 1'b1 : rd_cnt_q;
    assign rd_data    = mem_q[{rd_bank_q, rd_addr}];

    always_comb begin
        bank_full_d  = bank_full_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        dropping_d   = dropping_q;
        state_d      = state_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overflow_d   = 1'b0;
        wr_en        = 1'b0;
        rd_clear     = 1'b0;

        // Read side
        case (state_q)
            ST_IDLE: begin
                dout_valid_d = 1'b0;
                if (bank_full_q[rd_bank_q]) begin
                    rd_cnt_d = '0;
                    state_d  = ST_STREAM;
                end
            end
            default: begin
                if (!dout_valid_q) begin
                    // First bin of the frame is fetched one cycle after entry.
                    dout_valid_d = 1'b1;
                    dout_d       = rd_data;
                end else if (dout_ready) begin
                    if (rd_cnt_q == CNT_LAST) begin
                        rd_clear     = 1'b1;
                        dout_valid_d = 1'b0;
                        rd_cnt_d     = '0;
                        rd_bank_d    = ~rd_bank_q;
                        state_d      = ST_IDLE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                        dout_d   = rd_data;
                    end
                end
            end
        endcase

        // Write side. A bank freed by the reader this cycle can take a new
        // first sample in the same cycle, so the release is applied before
        // the drop check.
        clear_wr_bank = rd_clear && (rd_bank_q == wr_bank_q);
        first_sample  = data_in_valid && (wr_cnt_q == '0);
        drop_first    = first_sample && bank_full_q[wr_bank_q] && !clear_wr_bank;
        drop_cur      = first_sample ? drop_first : dropping_q;

        if (rd_clear) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end

        if (data_in_valid) begin
            wr_cnt_d   = wr_cnt_q + 1'b1;
            wr_en      = !drop_cur;
            overflow_d = drop_first;
            if (first_sample) begin
                dropping_d = drop_first;
            end
            if (wr_cnt_q == CNT_LAST) begin
                dropping_d = 1'b0;
                if (!drop_cur) begin
                    bank_full_d[wr_bank_q] = 1'b1;
                    wr_bank_d              = ~wr_bank_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full_q  <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            dropping_q   <= 1'b0;
            state_q      <= ST_IDLE;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            bank_full_q  <= bank_full_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            dropping_q   <= dropping_d;
            state_q      <= state_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_index = rd_cnt_q;
    assign dout_last  = dout_valid_q && (rd_cnt_q == CNT_LAST);
    assign overflow   = overflow_q;

endmodule
